// File: rtl/led_pattern_checker.sv
// -----------------------------------------------------------------------------
// led_pattern_checker
//
// Receive-side monitor for a 4-bit running-light LED bus. It locks onto the
// one-hot rotation. Once locked, it checks every step for the correct next
// pattern and for a dwell time inside the allowed window. It reports lock
// status, position, last accepted dwell, an error strobe with its cause, and
// a saturating error count.
//
// Parameters:
//   EXP_DWELL  expected cycles each pattern is held (must exceed DWELL_TOL)
//   DWELL_TOL  allowed +/- deviation of the dwell, in cycles
//   DIR        0 = rotate left (0001->0010->0100->1000), 1 = rotate right
//   CNT_W      dwell counter width, must hold EXP_DWELL+DWELL_TOL+1
//
// Ports:
//   sys_clk     in   1      clock, rising edge
//   sys_rst     in   1      synchronous reset, active-high
//   led_in      in   4      LED bus under observation
//   chk_en      in   1      checker enable; low forces IDLE
//   locked      out  1      high while tracking the rotation
//   pos         out  2      index of the lit LED, valid while locked
//   dwell_last  out  CNT_W  dwell of the last accepted pattern
//   err_pulse   out  1      one-cycle error strobe
//   err_code    out  2      01 SEQ, 10 ONEHOT, 11 TIMING; holds last cause
//   err_cnt     out  8      error count, saturates at 255
//
// Build option:
//   LED_PATTERN_SYNC_EN  when defined, led_in passes through a 2-flop
//                        synchroniser first. All detection latencies then
//                        grow by two cycles.
// -----------------------------------------------------------------------------
module led_pattern_checker #(
    parameter int unsigned EXP_DWELL = 10,
    parameter int unsigned DWELL_TOL = 0,
    parameter int unsigned DIR       = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [3:0]       led_in,
    input  logic             chk_en,
    output logic             locked,
    output logic [1:0]       pos,
    output logic [CNT_W-1:0] dwell_last,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] DWELL_LO = CNT_W'(EXP_DWELL - DWELL_TOL);
    localparam logic [CNT_W-1:0] DWELL_HI = CNT_W'(EXP_DWELL + DWELL_TOL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_SYNC,
        ST_TRACK
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SEQ    = 2'b01,
        ERR_ONEHOT = 2'b10,
        ERR_TIMING = 2'b11
    } err_e;

    state_e           state;
    state_e           state_next;
    logic [3:0]       led_s;
    logic [3:0]       led_prev;
    logic [CNT_W-1:0] dwell_cnt;
    logic             change;
    logic             s_onehot;
    logic [3:0]       exp_next;
    logic             err_hit;
    err_e             err_kind;
    logic             accept;
    logic             lock_enter;

    // -------------------------------------------------------------------------
    // Input sampling
    // -------------------------------------------------------------------------
`ifdef LED_PATTERN_SYNC_EN
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= led_in;
            sync_q2 <= sync_q1;
        end
    end

    assign led_s = sync_q2;
`else
    assign led_s = led_in;
`endif

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [3:0] rot_next(input logic [3:0] p);
        if (DIR == 0) begin
            return {p[2:0], p[3]};
        end else begin
            return {p[0], p[3:1]};
        end
    endfunction

    function automatic logic [1:0] hot_index(input logic [3:0] p);
        logic [1:0] idx;
        idx = 2'd0;
        case (p)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    assign change   = (led_s != led_prev);
    assign s_onehot = $onehot(led_s);
    assign exp_next = rot_next(led_prev);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and check decisions
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        err_hit    = 1'b0;
        err_kind   = ERR_NONE;
        accept     = 1'b0;
        lock_enter = 1'b0;

        // Disable outranks everything, including an error seen this cycle.
        if (!chk_en) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_ACQUIRE;
                end

                ST_ACQUIRE: begin
                    if (s_onehot) begin
                        state_next = ST_SYNC;
                    end
                end

                // The first pattern's dwell is partial, so only its successor is checked.
                ST_SYNC: begin
                    if (change) begin
                        if (led_s == exp_next) begin
                            state_next = ST_TRACK;
                            lock_enter = 1'b1;
                        end else begin
                            state_next = ST_ACQUIRE;
                        end
                    end
                end

                ST_TRACK: begin
                    if (change) begin
                        if (!s_onehot) begin
                            err_hit  = 1'b1;
                            err_kind = ERR_ONEHOT;
                        end else if (led_s != exp_next) begin
                            err_hit  = 1'b1;
                            err_kind = ERR_SEQ;
                        end else if ((dwell_cnt < DWELL_LO) || (dwell_cnt > DWELL_HI)) begin
                            err_hit  = 1'b1;
                            err_kind = ERR_TIMING;
                        end else begin
                            accept = 1'b1;
                        end
                    end else if (dwell_cnt == DWELL_HI) begin
                        // The count would step past the upper bound on this cycle, so the bus has stalled.
                        err_hit  = 1'b1;
                        err_kind = ERR_TIMING;
                    end

                    if (err_hit) begin
                        state_next = ST_ACQUIRE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_prev   <= '0;
            dwell_cnt  <= '0;
            locked     <= 1'b0;
            pos        <= '0;
            dwell_last <= '0;
            err_pulse  <= 1'b0;
            err_code   <= '0;
            err_cnt    <= '0;
        end else begin
            led_prev <= led_s;

            // Count restarts at 1 on a new pattern or when acquisition picks a candidate.
            if (change || ((state == ST_ACQUIRE) && s_onehot)) begin
                dwell_cnt <= CNT_W'(1);
            end else if (dwell_cnt != '1) begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end

            locked    <= (state_next == ST_TRACK);
            err_pulse <= err_hit;

            if (lock_enter || accept) begin
                pos <= hot_index(led_s);
            end

            if (accept) begin
                dwell_last <= dwell_cnt;
            end

            if (err_hit) begin
                err_code <= err_kind;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_checker.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_checker
//
// Directed bench for led_pattern_checker with the default parameters
// (EXP_DWELL=10, DWELL_TOL=0, DIR=0). It runs without the synchroniser
// macro. Inputs change 1 ns after each rising edge, and outputs are sampled
// at the same point.
// -----------------------------------------------------------------------------
module tb_led_pattern_checker;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  led_in;
    logic        chk_en;
    logic        locked;
    logic [1:0]  pos;
    logic [15:0] dwell_last;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    led_pattern_checker #(
        .EXP_DWELL(10),
        .DWELL_TOL(0),
        .DIR      (0),
        .CNT_W    (16)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .led_in    (led_in),
        .chk_en    (chk_en),
        .locked    (locked),
        .pos       (pos),
        .dwell_last(dwell_last),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] p, input int n);
        led_in = p;
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] lap_pat [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] lap_pos [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] bad_pat [6] = '{4'b0110, 4'b0110, 4'b0111, 4'b0000, 4'b1111, 4'b0011};

    initial begin
        int pulses;
        int exp_cnt;

        sys_rst = 1'b1;
        chk_en  = 1'b1;
        led_in  = 4'b0000;
        tick();
        tick();
        chk("rst_locked", 32'(locked), 32'(0));
        chk("rst_pos", 32'(pos), 32'(0));
        chk("rst_dwell_last", 32'(dwell_last), 32'(0));
        chk("rst_err_pulse", 32'(err_pulse), 32'(0));
        chk("rst_err_code", 32'(err_code), 32'(0));
        chk("rst_err_cnt", 32'(err_cnt), 32'(0));
        sys_rst = 1'b0;

        // 1: clean rotation, 10 cycles per pattern, three laps
        drive(4'b0001, 10);
        chk("t1_prelock", 32'(locked), 32'(0));
        for (int lap = 0; lap < 3; lap++) begin
            for (int s = 0; s < 4; s++) begin
                drive(lap_pat[s], 1);
                chk("t1_locked", 32'(locked), 32'(1));
                chk("t1_pos", 32'(pos), 32'(lap_pos[s]));
                chk("t1_dwell_last", 32'(dwell_last), ((lap == 0) && (s == 0)) ? 32'(0) : 32'(10));
                chk("t1_err_pulse", 32'(err_pulse), 32'(0));
                drive(lap_pat[s], 9);
            end
        end
        chk("t1_err_cnt", 32'(err_cnt), 32'(0));

        // 2: sequence error 0010 -> 1000, then relock
        drive(4'b0010, 1);
        chk("t2_pos", 32'(pos), 32'(1));
        drive(4'b0010, 9);
        drive(4'b1000, 1);
        chk("t2_err_pulse", 32'(err_pulse), 32'(1));
        chk("t2_err_code", 32'(err_code), 32'(1));
        chk("t2_err_cnt", 32'(err_cnt), 32'(1));
        chk("t2_locked", 32'(locked), 32'(0));
        drive(4'b1000, 1);
        chk("t2_pulse_end", 32'(err_pulse), 32'(0));
        drive(4'b1000, 8);
        drive(4'b0001, 1);
        chk("t2_relock", 32'(locked), 32'(1));
        chk("t2_relock_pos", 32'(pos), 32'(0));
        drive(4'b0001, 9);

        // 3: one-hot error 0100 -> 0110, then garbage in ACQUIRE
        drive(4'b0010, 1);
        chk("t3_locked", 32'(locked), 32'(1));
        drive(4'b0010, 9);
        drive(4'b0100, 1);
        chk("t3_pos", 32'(pos), 32'(2));
        drive(4'b0100, 9);
        drive(4'b0110, 1);
        chk("t3_err_pulse", 32'(err_pulse), 32'(1));
        chk("t3_err_code", 32'(err_code), 32'(2));
        chk("t3_err_cnt", 32'(err_cnt), 32'(2));
        chk("t3_locked_off", 32'(locked), 32'(0));
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            drive(bad_pat[i], 1);
            if (err_pulse) pulses++;
        end
        chk("t3_acq_pulses", 32'(pulses), 32'(0));
        chk("t3_acq_err_cnt", 32'(err_cnt), 32'(2));

        // 4a: short dwell (9 cycles) -> timing error
        drive(4'b0001, 5);
        chk("t4_sync_unlocked", 32'(locked), 32'(0));
        drive(4'b0010, 1);
        chk("t4_locked", 32'(locked), 32'(1));
        chk("t4_pos", 32'(pos), 32'(1));
        drive(4'b0010, 8);
        drive(4'b0100, 1);
        chk("t4_err_pulse", 32'(err_pulse), 32'(1));
        chk("t4_err_code", 32'(err_code), 32'(3));
        chk("t4_err_cnt", 32'(err_cnt), 32'(3));
        chk("t4_locked_off", 32'(locked), 32'(0));

        // 4b: relock, then hold 0010 forever -> exactly one stall error
        drive(4'b0100, 3);
        drive(4'b1000, 1);
        chk("t4b_locked", 32'(locked), 32'(1));
        chk("t4b_pos", 32'(pos), 32'(3));
        drive(4'b1000, 9);
        drive(4'b0001, 1);
        chk("t4b_pos0", 32'(pos), 32'(0));
        chk("t4b_dwell_last", 32'(dwell_last), 32'(10));
        drive(4'b0001, 9);
        drive(4'b0010, 1);
        chk("t4b_pos1", 32'(pos), 32'(1));
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (err_pulse) pulses++;
        end
        chk("t4b_early_pulses", 32'(pulses), 32'(0));
        chk("t4b_still_locked", 32'(locked), 32'(1));
        tick();
        chk("t4b_stall_pulse", 32'(err_pulse), 32'(1));
        chk("t4b_stall_code", 32'(err_code), 32'(3));
        chk("t4b_stall_cnt", 32'(err_cnt), 32'(4));
        chk("t4b_stall_unlock", 32'(locked), 32'(0));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (err_pulse) pulses++;
        end
        chk("t4b_later_pulses", 32'(pulses), 32'(0));
        chk("t4b_cnt_hold", 32'(err_cnt), 32'(4));

        // 6: chk_en drop coincident with a sequence error
        drive(4'b0100, 1);
        chk("t6_locked", 32'(locked), 32'(1));
        chk("t6_pos", 32'(pos), 32'(2));
        drive(4'b0100, 9);
        chk_en = 1'b0;
        drive(4'b0001, 1);
        chk("t6_no_pulse", 32'(err_pulse), 32'(0));
        chk("t6_unlocked", 32'(locked), 32'(0));
        chk("t6_cnt", 32'(err_cnt), 32'(4));
        chk("t6_code_hold", 32'(err_code), 32'(3));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            led_in = 4'($urandom_range(0, 15));
            tick();
            if (err_pulse) pulses++;
        end
        chk("t6_rand_pulses", 32'(pulses), 32'(0));
        chk("t6_rand_cnt", 32'(err_cnt), 32'(4));
        chk("t6_rand_locked", 32'(locked), 32'(0));
        chk("t6_dwell_last_hold", 32'(dwell_last), 32'(10));

        // 5: 300 errors -> count saturates at 255
        chk_en = 1'b1;
        drive(4'b0000, 1);
        for (int i = 0; i < 300; i++) begin
            drive(4'b0001, 1);
            drive(4'b0010, 1);
            drive(4'b1111, 1);
            exp_cnt = (5 + i > 255) ? 255 : 5 + i;
            chk("t5_err_cnt", 32'(err_cnt), 32'(exp_cnt));
        end
        chk("t5_last_pulse", 32'(err_pulse), 32'(1));
        chk("t5_last_code", 32'(err_code), 32'(2));

        // 5: reset mid-TRACK
        drive(4'b0001, 1);
        drive(4'b0010, 1);
        chk("t5_pre_rst_locked", 32'(locked), 32'(1));
        sys_rst = 1'b1;
        tick();
        tick();
        chk("t5_rst_locked", 32'(locked), 32'(0));
        chk("t5_rst_pos", 32'(pos), 32'(0));
        chk("t5_rst_dwell_last", 32'(dwell_last), 32'(0));
        chk("t5_rst_err_pulse", 32'(err_pulse), 32'(0));
        chk("t5_rst_err_code", 32'(err_code), 32'(0));
        chk("t5_rst_err_cnt", 32'(err_cnt), 32'(0));
        sys_rst = 1'b0;
        drive(4'b0010, 1);
        chk("t5_post_idle_pulse", 32'(err_pulse), 32'(0));
        chk("t5_post_idle_locked", 32'(locked), 32'(0));
        drive(4'b0010, 1);
        chk("t5_post_sync_locked", 32'(locked), 32'(0));
        drive(4'b0100, 1);
        chk("t5_post_relock", 32'(locked), 32'(1));
        chk("t5_post_pos", 32'(pos), 32'(2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/led_pattern_checker.md
Name: led_pattern_checker

Overview:
Receive-side companion to the running-light LED driver. Watches a 4-bit LED bus, locks onto the one-hot rotation, and checks every step for the correct next pattern and the correct dwell time in cycles. Reports lock status, position, last dwell time, an error pulse with cause, and a saturating error count. Used as an on-chip self-check and as a bench monitor.

Parameters:
EXP_DWELL, 10, expected cycles each pattern is held (must be > DWELL_TOL)
DWELL_TOL, 0, allowed ± deviation of dwell, in cycles
DIR, 0, 0 = rotate left (0001→0010→0100→1000→0001); 1 = rotate right
CNT_W, 16, dwell counter width; must hold EXP_DWELL+DWELL_TOL+1

Ports:
sys_clk  in  1  clock, rising edge
sys_rst  in  1  synchronous reset, active-high
led_in  in  4  LED bus under observation
chk_en  in  1  checker enable; low forces IDLE
locked  out  1  high while in TRACK
pos  out  2  index of current lit LED (0..3), valid when locked
dwell_last  out  CNT_W  dwell of the last accepted pattern
err_pulse  out  1  one-cycle error strobe
err_code  out  2  01 SEQ, 10 ONEHOT, 11 TIMING; holds last cause
err_cnt  out  8  error count, saturates at 255

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst. Reset sets all outputs to 0, the state to IDLE, led_prev to 0 and dwell_cnt to 0. Reset mid-operation aborts immediately; err_cnt clears only on reset.
- led_s is the sampled bus: led_in directly, or its synchronised copy (see Optional Feature). led_prev is led_s registered.
- A change is detected on the cycle led_s != led_prev.
- dwell_cnt = 1 on the first cycle of a new pattern. It increments each unchanged cycle and saturates at all-ones.
- next(p) = p rotated by 1 per DIR. One-hot means exactly one bit set.
- IDLE: locked=0. chk_en=1 → ACQUIRE.
- ACQUIRE: if led_s is one-hot → SYNC (dwell_cnt=1). Otherwise stay. No errors are flagged in ACQUIRE.
- SYNC: the first pattern's dwell is partial and is not checked.
  - Change to next(led_prev) → TRACK, locked=1, pos updated, dwell_cnt=1.
  - Any other change → ACQUIRE, no error.
- TRACK, on a change, checks in priority order:
  1. led_s not one-hot → ONEHOT error.
  2. led_s != next(led_prev) → SEQ error.
  3. dwell_cnt outside [EXP_DWELL-DWELL_TOL, EXP_DWELL+DWELL_TOL] → TIMING error.
  4. Otherwise accept: dwell_last = dwell_cnt, pos updated, dwell_cnt=1.
- TRACK, with no change: if dwell_cnt would reach EXP_DWELL+DWELL_TOL+1 → TIMING error (stall).
- On any error:
  - err_pulse=1 for exactly one cycle; err_code set; err_cnt += 1, saturating at 255.
  - locked=0; go to ACQUIRE. If led_s is one-hot, it is immediately taken as a SYNC candidate on the next cycle.
- Outputs are registered. err_pulse and locked update 1 cycle after the offending or qualifying led_s sample.
- chk_en=0 in any state → IDLE next cycle, locked=0. chk_en low has priority over a same-cycle error: no pulse, no count.
- dwell_last, err_code and err_cnt hold their values through IDLE.

Optional Feature:
- Macro: LED_PATTERN_SYNC_EN.
- Defined: led_in passes through a 2-flop synchroniser before led_s. All detection latencies increase by 2 cycles. Synchroniser flops reset to 0.
- Undefined: led_s = led_in; led_in is assumed synchronous to sys_clk.

Test Plan:
(defaults EXP_DWELL=10, DWELL_TOL=0, DIR=0, macro undefined)
1. Reset, chk_en=1, drive 0001/0010/0100/1000 repeating, 10 cycles each → locked=1 one cycle after the first transition; pos steps 1,2,3,0; dwell_last=10; err_cnt=0 across 3 full laps.
2. While locked, go 0010→1000 after 10 cycles → err_pulse for 1 cycle, err_code=01, err_cnt=1, locked=0; then relocks after the next correct transition.
3. While locked, go 0100→0110 → err_code=10, err_cnt increments, locked=0; non-one-hot values in ACQUIRE add no further errors.
4. While locked, hold 0010 for 9 cycles then advance → err_code=11. Separately, hold 0010 indefinitely → err_pulse once, on the cycle dwell_cnt would reach 11; exactly one error.
5. Drive 300 error events → err_cnt sticks at 255. Assert sys_rst for 2 cycles mid-TRACK → all outputs 0, state IDLE.
6. Drop chk_en in the same cycle as an SEQ error → no err_pulse, locked=0 next cycle, err_cnt unchanged. Random led_in while chk_en=0 → no errors.
